// File: rtl/mem_bus_arbiter.sv
// Two-cache shared-memory arbiter: one fixed-latency transaction at a time.
// Define MEMARB_FIXED_PRIO_EN to make A always win contention (default: round-robin).
module mem_bus_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int WORD_W    = 32,
    parameter int IOSTATE_W = 2,
    parameter int DELAY     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IOSTATE_W-1:0] rwFromCacheA,
    input  logic [ADDR_W-1:0]    addrFromCacheA,
    input  logic [WORD_W-1:0]    dataFromCacheA,
    output logic [WORD_W-1:0]    dataToCacheA,
    output logic                 memEnA,
    input  logic [IOSTATE_W-1:0] rwFromCacheB,
    input  logic [ADDR_W-1:0]    addrFromCacheB,
    input  logic [WORD_W-1:0]    dataFromCacheB,
    output logic [WORD_W-1:0]    dataToCacheB,
    output logic                 memEnB,
    output logic [IOSTATE_W-1:0] memRw,
    output logic [ADDR_W-1:0]    memAddr,
    output logic [WORD_W-1:0]    memWdata,
    output logic                 memStrobe,
    input  logic [WORD_W-1:0]    memRdata,
    output logic [IOSTATE_W-1:0] debugRwToMem,
    output logic [7:0]           debugDelay
);

    localparam logic [IOSTATE_W-1:0] RW_IDLE  = '0;
    localparam logic [IOSTATE_W-1:0] RW_READ  = IOSTATE_W'(1);
    localparam logic [IOSTATE_W-1:0] RW_WRITE = IOSTATE_W'(2);
    localparam logic [7:0]           CNT_INIT = 8'(DELAY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       last_b;
    logic       win_b;
    logic       mask_a;
    logic       mask_b;
    logic       req_a;
    logic       req_b;
    logic       grant_a;
    logic       grant_b;

    // The mask keeps a cache that was just served from winning again
    // on its stale, not-yet-dropped request.
    always_comb begin
        req_a = ((rwFromCacheA == RW_READ) || (rwFromCacheA == RW_WRITE)) && !mask_a;
        req_b = ((rwFromCacheB == RW_READ) || (rwFromCacheB == RW_WRITE)) && !mask_b;
`ifdef MEMARB_FIXED_PRIO_EN
        grant_a = req_a;
`else
        grant_a = req_a && (!req_b || last_b);
`endif
        grant_b = req_b && !grant_a;
    end

    assign memStrobe    = (state == S_BUSY) && (cnt == 8'd1);
    assign debugDelay   = (state == S_BUSY) ? cnt : 8'd0;
    assign debugRwToMem = memRw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= 8'd0;
            last_b       <= 1'b1;
            win_b        <= 1'b0;
            mask_a       <= 1'b0;
            mask_b       <= 1'b0;
            memRw        <= RW_IDLE;
            memAddr      <= '0;
            memWdata     <= '0;
            dataToCacheA <= '0;
            dataToCacheB <= '0;
            memEnA       <= 1'b0;
            memEnB       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    mask_a <= 1'b0;
                    mask_b <= 1'b0;
                    if (grant_a || grant_b) begin
                        state    <= S_BUSY;
                        cnt      <= CNT_INIT;
                        win_b    <= grant_b;
                        last_b   <= grant_b;
                        memRw    <= grant_b ? rwFromCacheB : rwFromCacheA;
                        memAddr  <= grant_b ? addrFromCacheB : addrFromCacheA;
                        memWdata <= grant_b ? dataFromCacheB : dataFromCacheA;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state  <= S_DONE;
                        memRw  <= RW_IDLE;
                        memEnA <= !win_b;
                        memEnB <= win_b;
                        if (memRw == RW_READ) begin
                            if (win_b) begin
                                dataToCacheB <= memRdata;
                            end else begin
                                dataToCacheA <= memRdata;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    memEnA <= 1'b0;
                    memEnB <= 1'b0;
                    mask_a <= !win_b;
                    mask_b <= win_b;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized cache traffic
// checked against a timeline model of grants, completions and memory.
module tb_mem_bus_arbiter;

    localparam int DELAY = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rwFromCacheA = 2'd0;
    logic [7:0]  addrFromCacheA = 8'd0;
    logic [31:0] dataFromCacheA = 32'd0;
    logic [31:0] dataToCacheA;
    logic        memEnA;
    logic [1:0]  rwFromCacheB = 2'd0;
    logic [7:0]  addrFromCacheB = 8'd0;
    logic [31:0] dataFromCacheB = 32'd0;
    logic [31:0] dataToCacheB;
    logic        memEnB;
    logic [1:0]  memRw;
    logic [7:0]  memAddr;
    logic [31:0] memWdata;
    logic        memStrobe;
    logic [31:0] memRdata;
    logic [1:0]  debugRwToMem;
    logic [7:0]  debugDelay;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(8), .WORD_W(32), .IOSTATE_W(2), .DELAY(DELAY)
    ) dut (
        .clk(clk), .reset(reset),
        .rwFromCacheA(rwFromCacheA), .addrFromCacheA(addrFromCacheA),
        .dataFromCacheA(dataFromCacheA), .dataToCacheA(dataToCacheA),
        .memEnA(memEnA),
        .rwFromCacheB(rwFromCacheB), .addrFromCacheB(addrFromCacheB),
        .dataFromCacheB(dataFromCacheB), .dataToCacheB(dataToCacheB),
        .memEnB(memEnB),
        .memRw(memRw), .memAddr(memAddr), .memWdata(memWdata),
        .memStrobe(memStrobe), .memRdata(memRdata),
        .debugRwToMem(debugRwToMem), .debugDelay(debugDelay)
    );

    // backing memory
    logic [31:0] mem [256];
    assign memRdata = mem[memAddr];
    always @(posedge clk) begin
        if (memStrobe && memRw == 2'd2) mem[memAddr] <= memWdata;
    end

    int passed = 0;
    int total = 0;

    // timeline model
    int          k = 0;
    int          free_at = 0;
    int          grant_edge = -1000;
    int          mask_edge = -1;
    bit          mask_b = 1'b0;
    bit          last_b = 1'b1;
    bit          win_b = 1'b0;
    logic [1:0]  g_rw = 2'd0;
    logic [7:0]  g_addr = 8'd0;
    logic [31:0] g_data = 32'd0;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_a = 32'd0;
    logic [31:0] exp_b = 32'd0;
    bit          stale_a = 1'b0;
    bit          stale_b = 1'b0;

    function automatic bit wants(input logic [1:0] rw);
        return rw == 2'd1 || rw == 2'd2;
    endfunction

    task automatic model_reset();
        free_at = k + 1;
        grant_edge = -1000;
        mask_edge = -1;
        last_b = 1'b1;
        exp_a = 32'd0;
        exp_b = 32'd0;
    endtask

    // advance one clock; the model sees the inputs exactly as the DUT does
    task automatic step();
        bit ra;
        bit rb;
        bit wb;
        @(posedge clk);
        k++;
        if (k == grant_edge + DELAY) begin
            if (g_rw == 2'd2) ref_mem[g_addr] = g_data;
            else if (win_b) exp_b = ref_mem[g_addr];
            else exp_a = ref_mem[g_addr];
        end
        if (k >= free_at) begin
            ra = wants(rwFromCacheA) && !(k == mask_edge && !mask_b);
            rb = wants(rwFromCacheB) && !(k == mask_edge && mask_b);
            if (ra || rb) begin
`ifdef MEMARB_FIXED_PRIO_EN
                wb = !ra;
`else
                wb = rb && (!ra || !last_b);
`endif
                grant_edge = k;
                free_at = k + DELAY + 2;
                mask_edge = k + DELAY + 2;
                mask_b = wb;
                last_b = wb;
                win_b = wb;
                g_rw = wb ? rwFromCacheB : rwFromCacheA;
                g_addr = wb ? addrFromCacheB : addrFromCacheA;
                g_data = wb ? dataFromCacheB : dataFromCacheA;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rwFromCacheA = 2'd0;
        rwFromCacheB = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic agent(input bit me, inout logic [1:0] rw,
                         inout logic [7:0] addr, inout logic [31:0] data,
                         inout bit stale);
        bit serv;
        serv = (win_b == me) && k >= grant_edge && k <= grant_edge + DELAY;
        if (stale) begin
            rw = 2'd0;
            stale = 1'b0;
        end else if (serv && k == grant_edge + DELAY) begin
            if ($urandom_range(3) == 0) stale = 1'b1;
            else rw = 2'd0;
        end else if (serv) begin
            if ($urandom_range(3) == 0) rw = 2'($urandom_range(3));
        end else if (wants(rw)) begin
            rw = rw;
        end else if ($urandom_range(2) == 0) begin
            rw = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(1, 2));
            addr = 8'($urandom_range(15));
            data = $urandom;
        end else begin
            rw = 2'd0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rwFromCacheA = 2'd1;
        rwFromCacheB = 2'd2;
        repeat (2) @(negedge clk);
        total++;
        if ({memEnA, memEnB, memStrobe, debugDelay} !== 11'd0)
            $display("FAIL reset_ctrl: got %b want 0", {memEnA, memEnB, memStrobe, debugDelay});
        else passed++;
        total++;
        if ({memRw, debugRwToMem, memAddr, memWdata} !== 44'd0)
            $display("FAIL reset_bus: got %h want 0", {memRw, debugRwToMem, memAddr, memWdata});
        else passed++;
        total++;
        if ({dataToCacheA, dataToCacheB} !== 64'd0)
            $display("FAIL reset_data: got %h want 0", {dataToCacheA, dataToCacheB});
        else passed++;
        rwFromCacheA = 2'd0;
        rwFromCacheB = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single_read();
        int strobe_at = -1;
        int en_at = -1;
        int en_cnt = 0;
        bit b_seen = 1'b0;
        logic [31:0] got = 32'd0;
        mem[8'h10] = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        rwFromCacheA = 2'd1;
        addrFromCacheA = 8'h10;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 1) begin
                total++;
                if (memRw !== 2'd1 || memAddr !== 8'h10)
                    $display("FAIL read_cmd: got %h/%h want 1/10", memRw, memAddr);
                else passed++;
            end
            if (memStrobe && strobe_at < 0) strobe_at = c;
            if (memEnA) begin
                en_cnt++;
                en_at = c;
                got = dataToCacheA;
                rwFromCacheA = 2'd0;
            end
            if (memEnB) b_seen = 1'b1;
        end
        total++;
        if (strobe_at !== DELAY)
            $display("FAIL read_strobe_cycle: got %0d want %0d", strobe_at, DELAY);
        else passed++;
        total++;
        if (en_at !== DELAY + 1 || en_cnt !== 1)
            $display("FAIL read_en: got cyc %0d cnt %0d want %0d 1", en_at, en_cnt, DELAY + 1);
        else passed++;
        total++;
        if (got !== 32'hDEADBEEF)
            $display("FAIL read_data: got %h want deadbeef", got);
        else passed++;
        total++;
        if (b_seen !== 1'b0)
            $display("FAIL read_no_enB: got %b want 0", b_seen);
        else passed++;
    endtask

    task automatic test_contention_writes();
        bit order[$];
        int done_a = 0;
        int done_b = 0;
        do_reset();
        rwFromCacheA = 2'd2; addrFromCacheA = 8'h01; dataFromCacheA = 32'h11;
        rwFromCacheB = 2'd2; addrFromCacheB = 8'h02; dataFromCacheB = 32'h22;
        for (int c = 0; c < 80 && (done_a < 2 || done_b < 2); c++) begin
            step();
            total++;
            if (memEnA && memEnB)
                $display("FAIL en_exclusive: got both want one");
            else passed++;
            if (memEnA) begin
                order.push_back(1'b0);
                done_a++;
                rwFromCacheA = 2'd0;
            end else if (rwFromCacheA == 2'd0 && done_a < 2) begin
                rwFromCacheA = 2'd2;
            end
            if (memEnB) begin
                order.push_back(1'b1);
                done_b++;
                rwFromCacheB = 2'd0;
            end else if (rwFromCacheB == 2'd0 && done_b < 2) begin
                rwFromCacheB = 2'd2;
            end
        end
        rwFromCacheA = 2'd0;
        rwFromCacheB = 2'd0;
        total++;
        if (order.size() != 4)
            $display("FAIL contention_count: got %0d want 4", order.size());
        else passed++;
        for (int i = 0; i < order.size() && i < 4; i++) begin
            total++;
            if (order[i] !== 1'(i % 2))
                $display("FAIL contention_order[%0d]: got %b want %b", i, order[i], 1'(i % 2));
            else passed++;
        end
        total++;
        if (mem[1] !== 32'h11 || mem[2] !== 32'h22)
            $display("FAIL contention_mem: got %h %h want 11 22", mem[1], mem[2]);
        else passed++;
    endtask

    task automatic test_write_then_read();
        bit seen = 1'b0;
        repeat (2) step();
        rwFromCacheB = 2'd2; addrFromCacheB = 8'h05; dataFromCacheB = 32'hCAFE;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (memEnB) seen = 1'b1;
        end
        rwFromCacheB = 2'd0;
        total++;
        if (!seen) $display("FAIL wr_timeout: got no memEnB want pulse");
        else passed++;
        step();
        seen = 1'b0;
        rwFromCacheA = 2'd1; addrFromCacheA = 8'h05;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (memEnA) seen = 1'b1;
        end
        rwFromCacheA = 2'd0;
        total++;
        if (!seen || dataToCacheA !== 32'hCAFE)
            $display("FAIL raw_data: got %h want cafe", dataToCacheA);
        else passed++;
        total++;
        if (dataToCacheB !== exp_b)
            $display("FAIL raw_other_hold: got %h want %h", dataToCacheB, exp_b);
        else passed++;
    endtask

    task automatic test_drop_mid_access();
        bit seen = 1'b0;
        repeat (2) step();
        rwFromCacheA = 2'd1; addrFromCacheA = 8'h03;
        repeat (3) step();
        rwFromCacheA = 2'd0;
        step();
        total++;
        if (memRw !== 2'd1)
            $display("FAIL drop_cmd_stable: got %0d want 1", memRw);
        else passed++;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (memEnA) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen || dataToCacheA !== ref_mem[3])
            $display("FAIL drop_complete: got %b %h want 1 %h", seen, dataToCacheA, ref_mem[3]);
        else passed++;
        repeat (2) step();
        seen = 1'b0;
        rwFromCacheA = 2'd1; addrFromCacheA = 8'h04;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            if (memEnA) seen = 1'b1;
        end
        step();
        step();
        rwFromCacheA = 2'd0;
        total++;
        if (!seen || memRw !== 2'd0 || debugDelay !== 8'd0)
            $display("FAIL mask_no_regrant: got %b %0d %0d want 1 0 0", seen, memRw, debugDelay);
        else passed++;
        step();
        total++;
        if (memRw !== 2'd0)
            $display("FAIL mask_after: got %0d want 0", memRw);
        else passed++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] old;
        bit strobe_seen = 1'b0;
        int en_at = -1;
        repeat (2) step();
        old = ref_mem[7];
        rwFromCacheB = 2'd2; addrFromCacheB = 8'h07; dataFromCacheB = 32'h77;
        repeat (3) step();
        total++;
        if (debugDelay !== 8'd2)
            $display("FAIL abort_cnt: got %0d want 2", debugDelay);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if ({memEnA, memEnB, memStrobe, memRw, memAddr, memWdata,
             dataToCacheA, dataToCacheB, debugDelay} !== '0)
            $display("FAIL abort_outputs: got %h %h %h want 0", memAddr, dataToCacheA, debugDelay);
        else passed++;
        repeat (3) begin
            @(negedge clk);
            if (memStrobe) strobe_seen = 1'b1;
        end
        total++;
        if (strobe_seen || mem[7] !== old)
            $display("FAIL abort_no_write: got %b %h want 0 %h", strobe_seen, mem[7], old);
        else passed++;
        reset = 1'b1;
        model_reset();
        for (int c = 1; c <= 12; c++) begin
            step();
            if (memEnB && en_at < 0) begin
                en_at = c;
                rwFromCacheB = 2'd0;
            end
        end
        total++;
        if (en_at !== DELAY + 1 || mem[7] !== 32'h77)
            $display("FAIL abort_resume: got %0d %h want %0d 77", en_at, mem[7], DELAY + 1);
        else passed++;
    endtask

    task automatic test_random(input int n);
        bit busy;
        bit en_now;
        logic [1:0] e_rw;
        int e_dly;
        int bad;
        rwFromCacheA = 2'd0;
        rwFromCacheB = 2'd0;
        for (int i = 0; i < n; i++) begin
            step();
            busy = k >= grant_edge && k < grant_edge + DELAY;
            en_now = k == grant_edge + DELAY;
            e_rw = busy ? g_rw : 2'd0;
            e_dly = busy ? grant_edge + DELAY - k : 0;
            total++;
            if (memEnA !== (en_now && !win_b))
                $display("FAIL rand_enA cyc %0d: got %b want %b", k, memEnA, en_now && !win_b);
            else passed++;
            total++;
            if (memEnB !== (en_now && win_b))
                $display("FAIL rand_enB cyc %0d: got %b want %b", k, memEnB, en_now && win_b);
            else passed++;
            total++;
            if (memStrobe !== (k == grant_edge + DELAY - 1))
                $display("FAIL rand_strobe cyc %0d: got %b", k, memStrobe);
            else passed++;
            total++;
            if (memRw !== e_rw || debugRwToMem !== e_rw)
                $display("FAIL rand_rw cyc %0d: got %0d/%0d want %0d", k, memRw, debugRwToMem, e_rw);
            else passed++;
            total++;
            if (int'(debugDelay) !== e_dly)
                $display("FAIL rand_delay cyc %0d: got %0d want %0d", k, debugDelay, e_dly);
            else passed++;
            if (busy) begin
                total++;
                if (memAddr !== g_addr || memWdata !== g_data)
                    $display("FAIL rand_bus cyc %0d: got %h %h want %h %h", k, memAddr, memWdata, g_addr, g_data);
                else passed++;
            end
            total++;
            if (dataToCacheA !== exp_a || dataToCacheB !== exp_b)
                $display("FAIL rand_rdata cyc %0d: got %h %h want %h %h", k, dataToCacheA, dataToCacheB, exp_a, exp_b);
            else passed++;
            agent(1'b0, rwFromCacheA, addrFromCacheA, dataFromCacheA, stale_a);
            agent(1'b1, rwFromCacheB, addrFromCacheB, dataFromCacheB, stale_b);
        end
        rwFromCacheA = 2'd0;
        rwFromCacheB = 2'd0;
        repeat (DELAY + 3) step();
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL rand_mem_image: got %0d differing words want 0", bad);
        else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_read();
        test_contention_writes();
        test_write_then_read();
        test_drop_mid_access();
        test_reset_abort();
        test_random(2000);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shared-memory controller placed between the two private caches and the single backing memory. It arbitrates cache A and cache B miss/write-back requests, sequences one memory transaction at a time with a fixed access delay, and returns read data plus a one-cycle completion strobe to the granted cache. Snoop traffic between the caches does not pass through this block.

Parameters:
ADDR_W, 8, address width (matches the cache address width)
WORD_W, 32, data word width
IOSTATE_W, 2, request-code width; 0 = IDLE, 1 = READ, 2 = WRITE, 3 = illegal and treated as IDLE
DELAY, 4, memory access cycles per transaction; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rwFromCacheA  in  IOSTATE_W  cache A request code
addrFromCacheA  in  ADDR_W  cache A address
dataFromCacheA  in  WORD_W  cache A write data
dataToCacheA  out  WORD_W  read data returned to A
memEnA  out  1  one-cycle completion strobe to A
rwFromCacheB  in  IOSTATE_W  cache B request code
addrFromCacheB  in  ADDR_W  cache B address
dataFromCacheB  in  WORD_W  cache B write data
dataToCacheB  out  WORD_W  read data returned to B
memEnB  out  1  one-cycle completion strobe to B
memRw  out  IOSTATE_W  command to the memory, held for the whole access
memAddr  out  ADDR_W  memory address
memWdata  out  WORD_W  memory write data
memStrobe  out  1  final access cycle: memory writes at this edge, and memRdata is sampled
memRdata  in  WORD_W  memory read data, combinational from memAddr
debugRwToMem  out  IOSTATE_W  copy of memRw
debugDelay  out  8  remaining access count, zero-extended

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE.
  - All outputs 0.
  - Last-grant pointer = B, so A wins the first contention.
  - Served-mask cleared.
  - No memStrobe is issued for any aborted access.
- States: IDLE, BUSY, DONE.
- IDLE:
  - reqX = (rwFromCacheX is READ or WRITE) AND X is not masked.
  - Only one requester: grant it.
  - Both requesting: grant the one not last granted (round-robin).
  - On the granting edge:
    - latch the winner's rw, address and write data into memRw, memAddr and memWdata;
    - set cnt = DELAY;
    - update the last-grant pointer;
    - go to BUSY.
  - Entering IDLE clears the mask after one cycle.
- BUSY:
  - memRw, memAddr and memWdata stay stable. Requester inputs are ignored; a requester dropping or changing rw mid-access has no effect.
  - cnt decrements each edge.
  - memStrobe = 1 combinationally while cnt == 1.
  - At the edge where cnt == 1:
    - READ: capture memRdata into dataToCacheX of the winner. The other cache's data output holds its value.
    - WRITE: the data output is unchanged.
    - memRw returns to 0.
    - Go to DONE.
- DONE:
  - memEnX = 1 for the winner, for exactly one cycle (registered).
  - Next edge: go to IDLE with the winner masked for that one IDLE cycle.
  - A cache must deassert rw in the cycle after it sees memEn. The mask prevents a stale duplicate grant.
- Latency: request present before edge E0 → memEnX high during the cycle following edge E0 + DELAY. DELAY = 1 gives memEn in the second cycle after the request.
- Throughput: a new grant can occur at the edge leaving the mask cycle. Back-to-back A/B contention strictly alternates.
- memEnA and memEnB are never both high.
- memStrobe never occurs outside BUSY.
- debugDelay = cnt in BUSY, else 0.
- Illegal code 3 never requests.

Optional Feature:
MEMARB_FIXED_PRIO_EN
- Defined: in IDLE, A always wins over B when both request. The pointer is not used, and the mask still applies.
- Undefined: round-robin as described above.

Test Plan:
1. DELAY = 4, A READ addr 0x10, memory[0x10] = 0xDEADBEEF → memStrobe on the 4th cycle after grant; memEnA pulses once with dataToCacheA = 0xDEADBEEF; memEnB stays 0.
2. A and B both WRITE in the same cycle (A: 0x01 ← 0x11, B: 0x02 ← 0x22), held until memEn → A served first, then B. Memory ends with 0x01 = 0x11 and 0x02 = 0x22. Grants alternate A, B, A, B over four repeated requests.
3. B WRITE 0x05 ← 0xCAFE, then A READ 0x05 → dataToCacheA = 0xCAFE and dataToCacheB unchanged.
4. Reset pulled low during BUSY with cnt = 2 → all outputs 0 immediately; no memStrobe; memory unchanged. After release, a pending B request is granted and completes normally.
5. A READ, then A drops rw to 0 after two BUSY cycles → the access still completes and memEnA pulses. A holding rw through the mask cycle gets no second grant in that cycle.
6. With MEMARB_FIXED_PRIO_EN, A and B requesting continuously → A is granted every available slot and B starves. Once A goes idle, B is granted on the next IDLE edge.
